comb_mc: RTL



---
 rtl/comb_mc.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/comb_mc.sv
`timescale 1ns/1ps
// Interleaved multi-channel comb: y = x[n] -/+ x[n-L] per channel; L is shared and only swapped at frame starts.
// Latency 3 cycles din_valid -> dout_valid; accepts one sample per cycle, no backpressure path.
module comb_mc #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 17,
  parameter int MAX_DELAY  = 1024,
  parameter int N_CHANNELS = 4,
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DIN_WIDTH-1:0]  din,
  input  logic                         din_valid,
  input  logic                         din_sync,
  input  logic [31:0]                  delay_line,
  input  logic                         mode,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic [CW-1:0]                dout_ch,
  output logic                         dout_valid,
  output logic                         primed
);

  localparam int PW    = $clog2(MAX_DELAY);
  localparam int LW    = PW + 1;
  localparam int DEPTH = MAX_DELAY * N_CHANNELS;
  localparam int AW    = $clog2(DEPTH);
  localparam int XW    = DOUT_WIDTH - DIN_WIDTH;

  logic [DIN_WIDTH-1:0] mem [DEPTH];
  logic [DIN_WIDTH-1:0] rd_dat;

  logic [LW-1:0] l_req, l_req_d, l_act, l_eff;
  logic [PW-1:0] ptr, ptr_eff, ptr_nxt;
  logic          fill, fill_eff, fill_nxt, first_smp;
  logic [CW-1:0] ch_nxt, smp_ch;
  logic          frame_bnd, flush, last_ch, wrap;
  logic [AW-1:0] addr;

  logic                         s1_vld, s1_fill, s1_primed, s1_mode;
  logic [DIN_WIDTH-1:0]         s1_din;
  logic [CW-1:0]                s1_ch;
  logic                         s2_vld, s2_primed;
  logic signed [DOUT_WIDTH-1:0] s2_y;
  logic [CW-1:0]                s2_ch;
  logic signed [DOUT_WIDTH-1:0] din_x, xd_x;

  always_comb begin
    if (delay_line == 32'd0) begin
      l_req_d = LW'(1);
    end else if (delay_line > 32'(MAX_DELAY)) begin
      l_req_d = LW'(MAX_DELAY);
    end else begin
      l_req_d = delay_line[LW-1:0];
    end
  end

  // A delay change restarts the line with empty history on the very sample that loads it.
  always_comb begin
    smp_ch    = din_sync ? '0 : ch_nxt;
    frame_bnd = (smp_ch == '0) || first_smp;
    l_eff     = frame_bnd ? l_req : l_act;
    flush     = frame_bnd && (l_req != l_act);
    ptr_eff   = flush ? '0 : ptr;
    fill_eff  = flush ? 1'b0 : fill;
    last_ch   = (smp_ch == CW'(N_CHANNELS - 1));
    wrap      = last_ch && ({1'b0, ptr_eff} == l_eff - LW'(1));
    ptr_nxt   = ptr_eff;
    if (last_ch) begin
      ptr_nxt = wrap ? '0 : ptr_eff + PW'(1);
    end
    fill_nxt  = fill_eff | wrap;
    addr      = AW'(ptr_eff) * AW'(N_CHANNELS) + AW'(smp_ch);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_req     <= LW'(MAX_DELAY);
      l_act     <= LW'(MAX_DELAY);
      ptr       <= '0;
      fill      <= 1'b0;
      first_smp <= 1'b1;
      ch_nxt    <= '0;
    end else begin
      l_req <= l_req_d;
      if (din_valid) begin
        first_smp <= 1'b0;
        ch_nxt    <= last_ch ? '0 : smp_ch + CW'(1);
        l_act     <= l_eff;
        ptr       <= ptr_nxt;
        fill      <= fill_nxt;
      end
    end
  end

  // Read-first RAM: the read returns the contents from before this write.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      mem[addr] <= din;
      rd_dat    <= mem[addr];
    end
  end

  always_comb begin
    din_x = {{XW{s1_din[DIN_WIDTH-1]}}, s1_din};
    xd_x  = s1_fill ? {{XW{rd_dat[DIN_WIDTH-1]}}, rd_dat} : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld     <= 1'b0;
      s1_din     <= '0;
      s1_ch      <= '0;
      s1_fill    <= 1'b0;
      s1_primed  <= 1'b0;
      s1_mode    <= 1'b0;
      s2_vld     <= 1'b0;
      s2_y       <= '0;
      s2_ch      <= '0;
      s2_primed  <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_ch    <= '0;
      primed     <= 1'b0;
    end else begin
      s1_vld <= din_valid;
      if (din_valid) begin
        s1_din    <= din;
        s1_ch     <= smp_ch;
        s1_fill   <= fill_eff;
        s1_primed <= fill_nxt;
        s1_mode   <= mode;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_y      <= s1_mode ? din_x + xd_x : din_x - xd_x;
        s2_ch     <= s1_ch;
        s2_primed <= s1_primed;
      end
      dout_valid <= s2_vld;
      if (s2_vld) begin
        dout    <= s2_y;
        dout_ch <= s2_ch;
        primed  <= s2_primed;
      end
    end
  end

endmodule
